// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//
// Bridges a 256-bit cache line interface to a 64-bit burst memory. A line
// read becomes a 4-beat read burst that is deserialized into the line buffer;
// a line write is latched into the same buffer and serialized out one beat at
// a time. Completion is signalled to the cache with a single-cycle cl_resp.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous, active-low reset
//   cl_read       line read request (held until cl_resp)
//   cl_write      line write request (held until cl_resp); wins over cl_read
//   cl_address    line address from the cache
//   cl_wdata256   line to write back
//   cl_rdata256   line buffer contents (assembled read line)
//   cl_resp       one-cycle completion pulse
//   pmem_address  line-aligned burst address
//   pmem_read     burst read request
//   pmem_write    burst write request
//   pmem_wdata64  current write beat
//   pmem_rdata64  current read beat
//   pmem_resp     beat accepted (write) / beat valid (read)
module cacheline_adaptor #(
    parameter int s_line   = 256,
    parameter int s_burst  = 64,
    parameter int s_offset = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cl_read,
    input  logic                cl_write,
    input  logic [31:0]         cl_address,
    input  logic [s_line-1:0]   cl_wdata256,
    output logic [s_line-1:0]   cl_rdata256,
    output logic                cl_resp,
    output logic [31:0]         pmem_address,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [s_burst-1:0]  pmem_wdata64,
    input  logic [s_burst-1:0]  pmem_rdata64,
    input  logic                pmem_resp
);

    localparam int beats = s_line / s_burst;
    localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [cnt_w-1:0]                cnt;
    logic [beats-1:0][s_burst-1:0]   buffer;
    logic [31:0]                     addr;
    logic [31:0]                     aligned_address;
    logic                            last_beat;

    // Masking rather than slicing keeps every address bit in use.
    assign aligned_address = cl_address & ~((32'd1 << s_offset) - 32'd1);
    assign last_beat       = (cnt == cnt_w'(beats - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cl_write) begin
                    state_next = WRITE;
                end else if (cl_read) begin
                    state_next = READ;
                end
            end
            READ, WRITE: begin
                if (pmem_resp && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The counter saturates at the last beat so it only returns to zero when
    // the next request is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            buffer <= '0;
            addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cl_write) begin
                        buffer <= cl_wdata256;
                        addr   <= aligned_address;
                        cnt    <= '0;
                    end else if (cl_read) begin
                        addr <= aligned_address;
                        cnt  <= '0;
                    end
                end
                READ: begin
                    if (pmem_resp) begin
                        buffer[cnt] <= pmem_rdata64;
                        if (!last_beat) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (pmem_resp && !last_beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pmem_read    = (state == READ);
    assign pmem_write   = (state == WRITE);
    assign cl_resp      = (state == DONE);
    assign pmem_address = addr;
    assign pmem_wdata64 = buffer[cnt];
    assign cl_rdata256  = buffer;

endmodule
